// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions: op encoding and field extraction.
package sm_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the extraction helpers handle; callers cast to their width.
  localparam int unsigned SM_MAX_W = 64;

  // Sign bit of a w-bit sign-magnitude word held zero-extended in v.
  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int unsigned w);
    return v[w-1];
  endfunction

  // Magnitude field (low w-1 bits) of a w-bit sign-magnitude word held in v.
  function automatic logic [SM_MAX_W-2:0] sm_mag(input logic [SM_MAX_W-1:0] v, input int unsigned w);
    logic [SM_MAX_W-1:0] mask;
    mask = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    return (SM_MAX_W-1)'(v & mask);
  endfunction

endpackage

// File: rtl/sm_mag_addsub.sv
// Combinational unsigned magnitude add or ordered subtract with carry out.
module sm_mag_addsub #(
  parameter int MAG_W = 31
) (
  input  logic [MAG_W-1:0] a,
  input  logic [MAG_W-1:0] b,
  input  logic             sub,
  input  logic             swap,
  output logic [MAG_W-1:0] mag,
  output logic             carry
);

  logic [MAG_W:0] sum;

  // Add produces a carry; subtract takes the larger minus the smaller, never borrowing.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    mag   = sum[MAG_W-1:0];
    carry = sum[MAG_W];
    if (sub) begin
      carry = 1'b0;
      mag   = swap ? (b - a) : (a - b);
    end
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with overflow flag,
// zero normalisation, valid/ready flow control and a saturating overflow counter.
module sm_addsub_pipe
  import sm_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  localparam int MAG_W = WIDTH - 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A zero magnitude without overflow always carries a positive sign.
  function automatic logic norm_sign(input logic s, input logic ovf, input logic [MAG_W-1:0] m);
    return (!ovf && (m == '0)) ? 1'b0 : s;
  endfunction

  logic                    adv;
  logic [SM_MAX_W-1:0]     a_ext, b_ext;
  logic                    sign_a_in, sbe_in;
  logic [MAG_W-1:0]        mag_a_in, mag_b_in;

  logic                    vld_p1, vld_p2;
  logic                    sign_a_p1, sbe_p1, eff_add_p1, a_ge_b_p1;
  logic [MAG_W-1:0]        mag_a_p1, mag_b_p1;

  logic [MAG_W-1:0]        mag_r;
  logic                    carry_r;
  logic                    sign_r;

  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  assign a_ext     = SM_MAX_W'(in_a);
  assign b_ext     = SM_MAX_W'(in_b);
  assign sign_a_in = sm_sign(a_ext, WIDTH);
  assign sbe_in    = sm_sign(b_ext, WIDTH) ^ (in_op == OP_SUB);
  assign mag_a_in  = MAG_W'(sm_mag(a_ext, WIDTH));
  assign mag_b_in  = MAG_W'(sm_mag(b_ext, WIDTH));

  // ---- stage 1: operand prep ----
  // Stage-1 valid; cleared by reset so in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= in_valid;
  end

  // Stage-1 operand fields, effective sign and magnitude ordering.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_a_p1  <= sign_a_in;
      sbe_p1     <= sbe_in;
      eff_add_p1 <= (sign_a_in == sbe_in);
      a_ge_b_p1  <= (mag_a_in >= mag_b_in);
      mag_a_p1   <= mag_a_in;
      mag_b_p1   <= mag_b_in;
    end
  end

  // ---- stage 2: magnitude arithmetic, registered to outputs ----
  sm_mag_addsub #(.MAG_W(MAG_W)) u_mag (
    .a     (mag_a_p1),
    .b     (mag_b_p1),
    .sub   (!eff_add_p1),
    .swap  (!a_ge_b_p1),
    .mag   (mag_r),
    .carry (carry_r)
  );

  assign sign_r = (eff_add_p1 || a_ge_b_p1) ? sign_a_p1 : sbe_p1;

  // Output register: result, overflow flag and valid advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      out_res <= '0;
      out_ovf <= 1'b0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      out_res <= {norm_sign(sign_r, carry_r, mag_r), mag_r};
      out_ovf <= carry_r;
    end
  end

  // Overflow event counter: clear wins over increment, increment saturates.
  always_ff @(posedge clk) begin
    if (rst || clr_count)                     ovf_count <= '0;
    else if (vld_p2 && out_ready && out_ovf)  ovf_count <= sat_inc(ovf_count);
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe at WIDTH=32 with hand-computed results.
module tb_sm_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_ovf;
  logic [15:0] ovf_count;
  logic        clr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One beat with out_ready=1: checks latency, result, overflow; optionally
  // pulses clr_count in the cycle of the output transfer.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic clr_at_out);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".res"}, out_res, exp_res);
    check({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
    clr_count = clr_at_out;
    @(posedge clk); #1;
    clr_count = 1'b0;
  endtask

  logic [31:0] got_q[$];
  int          sent;
  int          stall_left;
  bit          seen_first;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_res",   out_res, 32'd0);
    check("rst.out_ovf",   32'(out_ovf), 32'd0);
    check("rst.ovf_count", 32'(ovf_count), 32'd0);
    check("rst.in_ready",  32'(in_ready), 32'd1);

    run_one("sub_pos",  32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b0, 1'b0);
    run_one("sub_neg",  32'h80000005, 32'h80000003, 1'b1, 32'h80000002, 1'b0, 1'b0);
    run_one("flip1",    32'h00000003, 32'h00000005, 1'b1, 32'h80000002, 1'b0, 1'b0);
    run_one("flip2",    32'h00000005, 32'h80000003, 1'b1, 32'h00000008, 1'b0, 1'b0);
    run_one("flip3",    32'h80000005, 32'h00000003, 1'b0, 32'h80000002, 1'b0, 1'b0);
    run_one("negzero",  32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    run_one("eqsub",    32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b0, 1'b0);
    check("cnt.no_ovf", 32'(ovf_count), 32'd0);
    run_one("ovf",      32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    check("cnt.one", 32'(ovf_count), 32'd1);
    run_one("ovf_clr",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1);
    check("cnt.clr", 32'(ovf_count), 32'd0);

    // Backpressure: 4 back-to-back beats, first output stalled 3 cycles.
    sent = 0; stall_left = 0; seen_first = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid && !seen_first) begin
        seen_first = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 4);
      in_a      = 32'(sent + 1);
      in_b      = 32'(sent + 1);
      in_op     = 1'b0;
      @(negedge clk);
      if (stall_left > 0) begin
        check("bp.in_ready", 32'(in_ready), 32'd0);
        check("bp.hold",     out_res, 32'h00000002);
        stall_left--;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got_q.push_back(out_res);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp.count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check($sformatf("bp.out%0d", i), got_q[i], 32'(2 * (i + 1)));
    end

    // Reset mid-flight with a nonzero counter.
    run_one("ovf2", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    check("cnt.pre_rst", 32'(ovf_count), 32'd1);
    in_valid = 1'b1; in_a = 32'h7FFFFFFF; in_b = 32'h00000001; in_op = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h00000002; in_b = 32'h00000002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.out_res",   out_res, 32'd0);
    check("mrst.ovf_count", 32'(ovf_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("mrst.stale%0d", i), 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
